regfile_writeback_ctrl: RTL and testbench
=========================================

Name: regfile_writeback_ctrl

Overview:
- Write-side controller for the MIPS register file.
- Accepts completed results from the ALU and the load unit through valid/ready handshakes and buffers them in a small in-order FIFO.
- Issues at most one register-file write per cycle on the register file's write port (control, write_back_reg, wr).
- Sits between the execute/memory stages and registerfile.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width (32 registers).
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  ALU result will be accepted this edge.
- alu_dest  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- ld_valid  in  1  load result present.
- ld_ready  out  1  load result will be accepted this edge.
- ld_dest  in  ADDR_W  load destination register.
- ld_data  in  DATA_W  load data.
- wr  out  1  register-file write enable (registered).
- control  out  ADDR_W  register-file write address (registered).
- write_back_reg  out  DATA_W  register-file write data (registered).
- pending  out  $clog2(DEPTH)+1  FIFO occupancy.
- byp_rs  in  ADDR_W  bypass query A (BYPASS_EN only).
- byp_rt  in  ADDR_W  bypass query B (BYPASS_EN only).
- byp_rs_hit  out  1  query A hit.
- byp_rs_data  out  DATA_W  query A data.
- byp_rt_hit  out  1  query B hit.
- byp_rt_data  out  DATA_W  query B data.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO emptied; pending=0.
  - wr=0, control=0, write_back_reg=0.
  - Byp hit outputs 0, byp data outputs 0.
  - Takes effect immediately, including mid-operation; buffered entries are discarded.
- free = DEPTH - pending, computed from registered occupancy only; a same-cycle pop is not credited.
- Ready logic (combinational):
  - alu_ready = (free >= 1).
  - ld_ready = (free >= 2) | ((free == 1) & ~alu_valid).
- Enqueue:
  - A transfer occurs when valid & ready at the rising edge.
  - If both transfer in the same cycle, the ALU entry is enqueued first, then the load entry (program order).
  - ld_ready must not depend on ld_valid.
- Dequeue:
  - At each edge where pending > 0 (pre-edge value), the head is popped into the output registers.
  - A popped entry with dest != 0 drives wr=1, control=dest, write_back_reg=data for one cycle.
  - A popped entry with dest == 0 sets wr=0; the entry is discarded ($zero is never written).
- When pending == 0, wr=0 next cycle; control and write_back_reg hold their last values.
- Latency: an entry accepted at edge N into an empty FIFO produces wr=1 during cycle N+1..N+2; registerfile commits it at edge N+2. Throughput is 1 write/cycle.
- pending update: pending_next = pending + enq_count - (pending>0 ? 1 : 0), where enq_count is 0..2. It never exceeds DEPTH; overflow is impossible by construction.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full is pending == DEPTH; empty is pending == 0.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: byp_*_hit/data are combinational lookups for each query address q != 0.
  - Search order is newest-first: FIFO tail entries, then FIFO head, then the output register (if wr=1).
  - The first match gives hit=1 and its data.
  - q == 0 or no match gives hit=0, data=0.
- Undefined: byp_* outputs are tied to 0, byp_rs/byp_rt are ignored, and the search logic is absent.

Test Plan:
- Reset mid-stream: 3 entries queued, pull rst low between edges -> pending=0 and wr=0 immediately. After release, alu_ready=1 and no write of the discarded data ever appears.
- Single ALU write: alu_dest=5, alu_data=250 at edge N -> wr=1, control=5, write_back_reg=250 during cycle N+1; wr=0 in cycle N+2.
- Simultaneous sources into an empty FIFO: ALU (3, 275) and load (4, 300) in the same edge -> writes appear in order (3, 275) then (4, 300) on consecutive cycles; pending sequence is 2, 1, 0.
- Full/back-pressure (DEPTH=4): hold alu_valid=1 and ld_valid=1 -> alu_ready and ld_ready drop as free shrinks. When free==1 with alu_valid=1, ld_ready=0. No entry is lost, duplicated, or reordered over 20 cycles.
- $zero discard: alu_dest=0, data=0xDEADBEEF, followed by (8, 325) -> no wr pulse for dest 0, then wr=1 with control=8 and write_back_reg=325.
- Bypass (macro defined): queue (9, 350) then (9, 375), query byp_rs=9 and byp_rt=0 -> byp_rs_hit=1 with data 375, byp_rt_hit=0. With the macro undefined, all byp outputs are 0.

Source files
------------

// File: rtl/regfile_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_writeback_ctrl
//
// Write-side controller for the MIPS register file. Completed results from
// the ALU and the load unit arrive through valid/ready handshakes, are
// buffered in a small in-order FIFO, and are retired one per cycle onto the
// register file's write port (wr, control, write_back_reg).
//
// Optional feature macro: REGFILE_WB_BYPASS_EN
//   When defined, two combinational bypass queries (byp_rs, byp_rt) search
//   the buffered results newest-first so that younger instructions can pick
//   up values that have not yet reached the register file. When undefined,
//   the byp_* outputs are tied low and the search logic is absent.
//
// Ports:
//   clock          in   system clock, rising-edge active
//   rst            in   asynchronous active-low reset
//   alu_valid      in   ALU result present
//   alu_ready      out  ALU result accepted at the coming edge
//   alu_dest       in   ALU destination register
//   alu_data       in   ALU result
//   ld_valid       in   load result present
//   ld_ready       out  load result accepted at the coming edge
//   ld_dest        in   load destination register
//   ld_data        in   load data
//   wr             out  register-file write enable (registered)
//   control        out  register-file write address (registered)
//   write_back_reg out  register-file write data (registered)
//   pending        out  FIFO occupancy
//   byp_rs/byp_rt  in   bypass query addresses
//   byp_*_hit      out  bypass query hit flags
//   byp_*_data     out  bypass query data
// ---------------------------------------------------------------------------
module regfile_writeback_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_dest,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [ADDR_W-1:0]        ld_dest,
    input  logic [DATA_W-1:0]        ld_data,
    output logic                     wr,
    output logic [ADDR_W-1:0]        control,
    output logic [DATA_W-1:0]        write_back_reg,
    output logic [$clog2(DEPTH):0]   pending,
    input  logic [ADDR_W-1:0]        byp_rs,
    input  logic [ADDR_W-1:0]        byp_rt,
    output logic                     byp_rs_hit,
    output logic [DATA_W-1:0]        byp_rs_data,
    output logic                     byp_rt_hit,
    output logic [DATA_W-1:0]        byp_rt_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fifo_dest [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  ld_slot;
    logic [CNT_W-1:0]  free;
    logic              alu_fire;
    logic              ld_fire;
    logic              do_pop;
    logic [1:0]        enq_count;
    logic [ADDR_W-1:0] head_dest;
    logic [DATA_W-1:0] head_data;

    // Free space is taken from the registered occupancy only. A pop happening
    // at the same edge is deliberately not credited, which keeps the ready
    // paths short and independent of the pop decision.
    assign free = CNT_W'(DEPTH) - pending;

    // The load port needs two free slots unless the ALU is idle this cycle,
    // because a simultaneous ALU transfer takes the first free slot. ld_ready
    // never looks at ld_valid, so the handshake cannot form a loop.
    assign alu_ready = (free != '0);
    assign ld_ready  = (free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !alu_valid);

    assign alu_fire  = alu_valid && alu_ready;
    assign ld_fire   = ld_valid && ld_ready;
    assign enq_count = {1'b0, alu_fire} + {1'b0, ld_fire};

    // The ALU result is older in program order, so when both transfer it
    // takes the tail slot and the load goes right behind it.
    assign ld_slot = wr_ptr + PTR_W'(alu_fire);

    assign do_pop    = (pending != '0);
    assign head_dest = fifo_dest[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    // FIFO storage. Entries carry no reset: occupancy alone decides which
    // slots are meaningful, so stale contents are never observed.
    always_ff @(posedge clock) begin
        if (alu_fire) begin
            fifo_dest[wr_ptr] <= alu_dest;
            fifo_data[wr_ptr] <= alu_data;
        end
        if (ld_fire) begin
            fifo_dest[ld_slot] <= ld_dest;
            fifo_data[ld_slot] <= ld_data;
        end
    end

    // Pointer and occupancy bookkeeping. Because free ignores the pop, the
    // count can never pass DEPTH and the write slots never collide with the
    // head while it is being read.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PTR_W'(enq_count);
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            pending <= pending + CNT_W'(enq_count) - CNT_W'(do_pop);
        end
    end

    // Register-file write port. Every non-empty cycle retires the head; a
    // head aimed at $zero is dropped without a write and without disturbing
    // the held address/data. With nothing to retire, wr falls and the last
    // address/data are held.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr             <= 1'b0;
            control        <= '0;
            write_back_reg <= '0;
        end else if (do_pop && (head_dest != '0)) begin
            wr             <= 1'b1;
            control        <= head_dest;
            write_back_reg <= head_data;
        end else begin
            wr             <= 1'b0;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN

    // Returns {hit, data} for one query. The output register is the oldest
    // candidate, then the FIFO from head to tail; later matches overwrite
    // earlier ones so the newest matching result wins.
    function automatic logic [DATA_W:0] byp_search(input logic [ADDR_W-1:0] q);
        logic [DATA_W:0]  r;
        logic [PTR_W-1:0] idx;
        r = '0;
        if (q != '0) begin
            if (wr && (control == q)) begin
                r = {1'b1, write_back_reg};
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + PTR_W'(i);
                if ((CNT_W'(i) < pending) && (fifo_dest[idx] == q)) begin
                    r = {1'b1, fifo_data[idx]};
                end
            end
        end
        return r;
    endfunction

    // Two independent lookups, one per source operand of the consumer.
    always_comb begin
        logic [DATA_W:0] rs_res;
        logic [DATA_W:0] rt_res;
        rs_res      = byp_search(byp_rs);
        rt_res      = byp_search(byp_rt);
        byp_rs_hit  = rs_res[DATA_W];
        byp_rs_data = rs_res[DATA_W-1:0];
        byp_rt_hit  = rt_res[DATA_W];
        byp_rt_data = rt_res[DATA_W-1:0];
    end

`else

    // Bypass disabled: outputs are constant and the query inputs are only
    // gathered here so they are visibly consumed.
    logic unused_byp;
    assign unused_byp  = ^{byp_rs, byp_rt};
    assign byp_rs_hit  = 1'b0;
    assign byp_rs_data = '0;
    assign byp_rt_hit  = 1'b0;
    assign byp_rt_data = '0;

`endif

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_writeback_ctrl
//
// Directed bench for regfile_writeback_ctrl with hand-computed expectations:
// reset state, single ALU write, simultaneous sources, back-pressure with
// ordering, $zero discard, mid-stream reset and bypass lookups.
// ---------------------------------------------------------------------------
module tb_regfile_writeback_ctrl;

    logic        clock;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_dest;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_dest;
    logic [31:0] ld_data;
    logic        wr;
    logic [4:0]  control;
    logic [31:0] write_back_reg;
    logic [2:0]  pending;
    logic [4:0]  byp_rs;
    logic [4:0]  byp_rt;
    logic        byp_rs_hit;
    logic [31:0] byp_rs_data;
    logic        byp_rt_hit;
    logic [31:0] byp_rt_data;

    int checks;
    int failures;

    logic [4:0]  exp_dest [22];
    logic [31:0] exp_data [22];

    regfile_writeback_ctrl #(
        .DATA_W(32),
        .ADDR_W(5),
        .DEPTH (4)
    ) dut (
        .clock         (clock),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_dest      (alu_dest),
        .alu_data      (alu_data),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_dest       (ld_dest),
        .ld_data       (ld_data),
        .wr            (wr),
        .control       (control),
        .write_back_reg(write_back_reg),
        .pending       (pending),
        .byp_rs        (byp_rs),
        .byp_rt        (byp_rt),
        .byp_rs_hit    (byp_rs_hit),
        .byp_rs_data   (byp_rs_data),
        .byp_rt_hit    (byp_rt_hit),
        .byp_rt_data   (byp_rt_data)
    );

    // Free-running 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drive both producer ports at once.
    task automatic applyStimulus(input logic av, input logic [4:0] ad, input logic [31:0] adata,
                                 input logic lv, input logic [4:0] ldst, input logic [31:0] ldat);
        alu_valid = av;
        alu_dest  = ad;
        alu_data  = adata;
        ld_valid  = lv;
        ld_dest   = ldst;
        ld_data   = ldat;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected retirement order for the back-pressure run:
    // A0, L0, A1, L1, then A2..A19 (loads starve once free reaches 1).
    initial begin
        exp_dest[0] = 5'd1;  exp_data[0] = 32'h100;
        exp_dest[1] = 5'd20; exp_data[1] = 32'h200;
        exp_dest[2] = 5'd2;  exp_data[2] = 32'h101;
        exp_dest[3] = 5'd21; exp_data[3] = 32'h201;
        for (int i = 4; i < 22; i++) begin
            exp_dest[i] = 5'(((i - 2) % 7) + 1);
            exp_data[i] = 32'h100 + 32'(i - 2);
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        byp_rs   = 5'd9;
        byp_rt   = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Reset state
        rst = 1'b0;
        #2;
        checkOutput("rst_pending", 32'(pending), 32'd0);
        checkOutput("rst_wr", 32'(wr), 32'd0);
        checkOutput("rst_control", 32'(control), 32'd0);
        checkOutput("rst_wbdata", write_back_reg, 32'd0);
        checkOutput("rst_alu_ready", 32'(alu_ready), 32'd1);
        checkOutput("rst_ld_ready", 32'(ld_ready), 32'd1);
        checkOutput("rst_byp_hit", 32'(byp_rs_hit), 32'd0);
        checkOutput("rst_byp_data", byp_rs_data, 32'd0);
        @(negedge clock);
        rst = 1'b1;
        tick();

        // Single ALU write (5, 250)
        applyStimulus(1'b1, 5'd5, 32'd250, 1'b0, 5'd0, 32'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("single_pending_n", 32'(pending), 32'd1);
        checkOutput("single_wr_n", 32'(wr), 32'd0);
        tick();
        checkOutput("single_wr", 32'(wr), 32'd1);
        checkOutput("single_control", 32'(control), 32'd5);
        checkOutput("single_data", write_back_reg, 32'd250);
        checkOutput("single_pending", 32'(pending), 32'd0);
        tick();
        checkOutput("single_wr_off", 32'(wr), 32'd0);
        checkOutput("single_control_hold", 32'(control), 32'd5);
        checkOutput("single_data_hold", write_back_reg, 32'd250);

        // Simultaneous ALU (3, 275) and load (4, 300)
        applyStimulus(1'b1, 5'd3, 32'd275, 1'b1, 5'd4, 32'd300);
        #1;
        checkOutput("sim_alu_ready", 32'(alu_ready), 32'd1);
        checkOutput("sim_ld_ready", 32'(ld_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("sim_pending0", 32'(pending), 32'd2);
        checkOutput("sim_wr0", 32'(wr), 32'd0);
        tick();
        checkOutput("sim_wr1", 32'(wr), 32'd1);
        checkOutput("sim_control1", 32'(control), 32'd3);
        checkOutput("sim_data1", write_back_reg, 32'd275);
        checkOutput("sim_pending1", 32'(pending), 32'd1);
        tick();
        checkOutput("sim_wr2", 32'(wr), 32'd1);
        checkOutput("sim_control2", 32'(control), 32'd4);
        checkOutput("sim_data2", write_back_reg, 32'd300);
        checkOutput("sim_pending2", 32'(pending), 32'd0);
        tick();
        checkOutput("sim_wr3", 32'(wr), 32'd0);

        // $zero discard: (0, DEADBEEF) then (8, 325)
        applyStimulus(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        tick();
        applyStimulus(1'b1, 5'd8, 32'd325, 1'b0, 5'd0, 32'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("zero_wr", 32'(wr), 32'd0);
        checkOutput("zero_control_hold", 32'(control), 32'd4);
        checkOutput("zero_data_hold", write_back_reg, 32'd300);
        checkOutput("zero_pending", 32'(pending), 32'd1);
        tick();
        checkOutput("zero_next_wr", 32'(wr), 32'd1);
        checkOutput("zero_next_control", 32'(control), 32'd8);
        checkOutput("zero_next_data", write_back_reg, 32'd325);
        tick();
        checkOutput("zero_idle_wr", 32'(wr), 32'd0);

        // Back-pressure: both sources held valid for 20 cycles
        for (int k = 0; k < 20; k++) begin
            int li;
            li = (k < 2) ? k : 2;
            applyStimulus(1'b1, 5'((k % 7) + 1), 32'h100 + 32'(k),
                          1'b1, 5'(20 + li), 32'h200 + 32'(li));
            #1;
            checkOutput("bp_alu_ready", 32'(alu_ready), 32'd1);
            checkOutput("bp_ld_ready", 32'(ld_ready), (k < 2) ? 32'd1 : 32'd0);
            tick();
            checkOutput("bp_pending", 32'(pending), (k == 0) ? 32'd2 : 32'd3);
            if (k >= 1) begin
                checkOutput("bp_wr", 32'(wr), 32'd1);
                checkOutput("bp_control", 32'(control), 32'(exp_dest[k-1]));
                checkOutput("bp_data", write_back_reg, exp_data[k-1]);
            end
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int j = 0; j < 3; j++) begin
            tick();
            checkOutput("drain_wr", 32'(wr), 32'd1);
            checkOutput("drain_control", 32'(control), 32'(exp_dest[19+j]));
            checkOutput("drain_data", write_back_reg, exp_data[19+j]);
            checkOutput("drain_pending", 32'(pending), 32'(2 - j));
        end
        tick();
        checkOutput("drain_wr_off", 32'(wr), 32'd0);

        // Mid-stream reset with three entries queued
        applyStimulus(1'b1, 5'd11, 32'h111, 1'b1, 5'd12, 32'h222);
        tick();
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("mrst_pending_before", 32'(pending), 32'd3);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("mrst_pending", 32'(pending), 32'd0);
        checkOutput("mrst_wr", 32'(wr), 32'd0);
        checkOutput("mrst_control", 32'(control), 32'd0);
        checkOutput("mrst_data", write_back_reg, 32'd0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("mrst_alu_ready", 32'(alu_ready), 32'd1);
        for (int j = 0; j < 4; j++) begin
            tick();
            checkOutput("mrst_no_wr", 32'(wr), 32'd0);
            checkOutput("mrst_empty", 32'(pending), 32'd0);
        end

        // Bypass: (9, 350) then (9, 375); query rs=9, rt=0
        applyStimulus(1'b1, 5'd9, 32'd350, 1'b0, 5'd0, 32'd0);
        tick();
        applyStimulus(1'b1, 5'd9, 32'd375, 1'b0, 5'd0, 32'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        byp_rs = 5'd9;
        byp_rt = 5'd0;
        #1;
`ifdef REGFILE_WB_BYPASS_EN
        checkOutput("byp_rs_hit", 32'(byp_rs_hit), 32'd1);
        checkOutput("byp_rs_data", byp_rs_data, 32'd375);
`else
        checkOutput("byp_rs_hit", 32'(byp_rs_hit), 32'd0);
        checkOutput("byp_rs_data", byp_rs_data, 32'd0);
`endif
        checkOutput("byp_rt_hit", 32'(byp_rt_hit), 32'd0);
        checkOutput("byp_rt_data", byp_rt_data, 32'd0);
        tick();
        checkOutput("byp_final_wr", 32'(wr), 32'd1);
        checkOutput("byp_final_data", write_back_reg, 32'd375);
`ifdef REGFILE_WB_BYPASS_EN
        checkOutput("byp_out_reg_hit", 32'(byp_rs_hit), 32'd1);
        checkOutput("byp_out_reg_data", byp_rs_data, 32'd375);
`else
        checkOutput("byp_out_reg_hit", 32'(byp_rs_hit), 32'd0);
        checkOutput("byp_out_reg_data", byp_rs_data, 32'd0);
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
